mon_date_counter: RTL and testbench
===================================

// Module: mon_date_counter
// PURPOSE
//  Calendar month/date register for the clock's date-setting path.
//  Receives the one-cycle increment pulses made by the rising-edge pulse
//  generators on the set buttons, plus the midnight carry from the
//  time-of-day counter.
//  Holds month (01-12) and date (01-28/29/30/31) as BCD for the 7-segment
//  display, and emits a one-cycle year-carry pulse at the Dec 31 rollover.
// PARAMETERS
//  INIT_MON   8'h01  BCD month loaded at reset
//  INIT_DATE  8'h01  BCD date loaded at reset; must be valid for INIT_MON
// PORTS
//  clk         in   1  system clock; all state updates on posedge
//  rst         in   1  asynchronous, active-high reset
//  day_carry   in   1  1-cycle pulse from time counter at 23:59:59->00:00:00
//  inc_mon     in   1  1-cycle pulse from month-set button pulse generator
//  inc_date    in   1  1-cycle pulse from date-set button pulse generator
//  leap_year   in   1  level; 1 = February has 29 days
//  mon_bcd     out  8  month, BCD [7:4] tens (0-1), [3:0] ones
//  date_bcd    out  8  date, BCD [7:4] tens (0-3), [3:0] ones
//  year_carry  out  1  registered 1-cycle pulse on auto 12/31 -> 01/01
// BEHAVIOUR
//  - Reset (async, rst=1):
//    - mon_bcd=INIT_MON, date_bcd=INIT_DATE, year_carry=0.
//    - Reset wins over any pulse in flight.
//  - Every input is sampled at posedge clk. Outputs are registered.
//    - Latency is 1 cycle: the pulse at edge N is visible after edge N.
//    - Each cycle an input is high counts as one event; the block does no
//      edge detection of its own.
//  - dim = days_in_month(mon_bcd, leap_year):
//    - 31 for months 01,03,05,07,08,10,12.
//    - 30 for months 04,06,09,11.
//    - 28 or 29 for month 02, per leap_year.
//  - Priority when inputs coincide: day_carry > inc_mon > inc_date.
//    - Events that lose arbitration in a cycle are dropped, not queued.
//  - States of each cycle, evaluated in priority order:
//    - AUTO (day_carry=1):
//      - date<dim: date+1.
//      - date==dim: date=01 and month+1.
//      - month==12 at rollover: month=01 and year_carry=1 on the next cycle.
//    - SET_MON (inc_mon=1):
//      - month+1, wrapping 12->01. year_carry stays 0.
//      - Date is then clamped: if date > dim(new month), date = dim(new month).
//        Example: 01/31 -> 02/28 (leap_year=0).
//    - SET_DATE (inc_date=1):
//      - date+1, wrapping dim->01. The month is unchanged.
//    - IDLE (no input high): hold. year_carry=0.
//  - BCD arithmetic:
//    - Ones digit 9 -> 0 with a carry into tens.
//    - The wrap compare is a full 8-bit BCD compare against dim.
//    - Outputs never hold a non-BCD nibble, month 00, or date 00.
//  - leap_year changing while month=02 and date=29 with leap_year -> 0:
//    - No immediate clamp.
//    - The next AUTO or SET_DATE event treats date>=dim as a wrap.
//    - The next SET_MON event clamps as above.
//  - year_carry is high for exactly 1 cycle and never on consecutive cycles
//    unless day_carry repeats at 12/31.
// STRUCTURE
//  - Shared header/package:
//    - BCD month constants (MON_JAN..MON_DEC).
//    - The day-count constants 8'h28, 8'h29, 8'h30, 8'h31.
//    - The one-hot priority encodings.
//  - Sub-module mon_days_lut: combinational (mon_bcd, leap_year) -> dim_bcd.
//    It is instantiated twice: once for the current month, once for the
//    next month used by the clamp.
//  - Top level: priority select, BCD incrementers, month/date/year_carry regs.
// TESTING
//  - Reset with INIT defaults -> mon=8'h01, date=8'h01, year_carry=0.
//    Assert rst mid-count -> outputs return to defaults asynchronously.
//  - Date sweep in Feb:
//    - Preload 02/28, leap_year=0, day_carry -> 03/01.
//    - Repeat from 02/28 with leap_year=1 -> 02/29, then day_carry -> 03/01.
//  - Year rollover: 12/31 + day_carry -> 01/01, with year_carry=1 for exactly
//    the next cycle, then 0.
//  - Manual set, starting from 01/31:
//    - inc_mon -> 02/28.
//    - inc_mon x10 more -> 12/28, then inc_mon -> 01/28, year_carry stays 0.
//  - inc_date at 04/30 -> 04/01 with the month unchanged.
//  - Priority checks:
//    - At 03/31, day_carry and inc_mon high together -> 04/01.
//      The inc_mon is dropped.
//    - At 05/10, inc_mon and inc_date high together -> 06/10.
//  - Random pulses for 10k cycles:
//    - mon_bcd/date_bcd stay valid BCD within 01..12 and 01..dim.
//    - Results match a reference model.

Source files
------------

// File: rtl/mon_date_counter_pkg.sv
// Shared constants and helpers for the calendar month/date register.
// Holds the BCD month codes, the BCD day-count values, the one-hot
// per-cycle operation encoding and a BCD increment helper.
package mon_date_counter_pkg;

  localparam logic [7:0] MON_JAN = 8'h01;
  localparam logic [7:0] MON_FEB = 8'h02;
  localparam logic [7:0] MON_MAR = 8'h03;
  localparam logic [7:0] MON_APR = 8'h04;
  localparam logic [7:0] MON_MAY = 8'h05;
  localparam logic [7:0] MON_JUN = 8'h06;
  localparam logic [7:0] MON_JUL = 8'h07;
  localparam logic [7:0] MON_AUG = 8'h08;
  localparam logic [7:0] MON_SEP = 8'h09;
  localparam logic [7:0] MON_OCT = 8'h10;
  localparam logic [7:0] MON_NOV = 8'h11;
  localparam logic [7:0] MON_DEC = 8'h12;

  localparam logic [7:0] DIM_28     = 8'h28;
  localparam logic [7:0] DIM_29     = 8'h29;
  localparam logic [7:0] DIM_30     = 8'h30;
  localparam logic [7:0] DIM_31     = 8'h31;
  localparam logic [7:0] DATE_FIRST = 8'h01;

  // One-hot operation selected each cycle, highest priority in the MSB.
  typedef enum logic [3:0] {
    OP_IDLE     = 4'b0001,
    OP_SET_DATE = 4'b0010,
    OP_SET_MON  = 4'b0100,
    OP_AUTO     = 4'b1000
  } op_e;

  // Two-digit BCD increment; ones 9 -> 0 carries into tens.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/mon_date_counter_days_lut.sv
// Days-in-month lookup (combinational).
// Ports:
//   mon_bcd   in  8  BCD month 01..12
//   leap_year in  1  1 = February has 29 days
//   dim_bcd   out 8  BCD number of days in mon_bcd
module mon_days_lut
  import mon_date_counter_pkg::*;
(
  input  logic [7:0] mon_bcd,
  input  logic       leap_year,
  output logic [7:0] dim_bcd
);

  always_comb begin
    dim_bcd = DIM_31;
    case (mon_bcd)
      MON_APR, MON_JUN, MON_SEP, MON_NOV: dim_bcd = DIM_30;
      MON_FEB:                            dim_bcd = leap_year ? DIM_29 : DIM_28;
      default:                            dim_bcd = DIM_31;
    endcase
  end

endmodule

// File: rtl/mon_date_counter.sv
// Calendar month/date register for the date-setting path.
// Counts days from the midnight carry, accepts month/date set pulses,
// and flags the Dec 31 -> Jan 01 rollover with a one-cycle year carry.
// Ports:
//   clk        in   1  system clock
//   rst        in   1  asynchronous active-high reset
//   day_carry  in   1  midnight pulse from the time-of-day counter
//   inc_mon    in   1  month-set pulse
//   inc_date   in   1  date-set pulse
//   leap_year  in   1  level, 1 = February has 29 days
//   mon_bcd    out  8  BCD month 01..12
//   date_bcd   out  8  BCD date 01..dim
//   year_carry out  1  registered pulse on automatic 12/31 -> 01/01
//
// Per-cycle operation (decoded combinationally, no state of its own):
//   op          | meaning
//   OP_AUTO     | day_carry: advance date, roll month/year at end of month
//   OP_SET_MON  | inc_mon: advance month, clamp date to new month length
//   OP_SET_DATE | inc_date: advance date, wrap within current month
//   OP_IDLE     | hold
module mon_date_counter
  import mon_date_counter_pkg::*;
#(
  parameter logic [7:0] INIT_MON  = 8'h01,
  parameter logic [7:0] INIT_DATE = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       day_carry,
  input  logic       inc_mon,
  input  logic       inc_date,
  input  logic       leap_year,
  output logic [7:0] mon_bcd,
  output logic [7:0] date_bcd,
  output logic       year_carry
);

  op_e        op;
  logic [7:0] dim_cur;
  logic [7:0] dim_nxt;
  logic [7:0] mon_inc;
  logic [7:0] date_inc;
  logic       mon_wrap;
  logic       date_wrap;
  logic [7:0] mon_d;
  logic [7:0] date_d;
  logic       year_carry_d;

  mon_days_lut u_dim_cur (
    .mon_bcd   (mon_bcd),
    .leap_year (leap_year),
    .dim_bcd   (dim_cur)
  );

  assign mon_wrap = (mon_bcd >= MON_DEC);
  assign mon_inc  = mon_wrap ? MON_JAN : bcd_inc(mon_bcd);

  // Length of the month we would move to; used only by the set-month clamp.
  mon_days_lut u_dim_nxt (
    .mon_bcd   (mon_inc),
    .leap_year (leap_year),
    .dim_bcd   (dim_nxt)
  );

  // >= rather than == so a stale 29 Feb after leap_year drops still wraps.
  // BCD ordering matches binary ordering, so a plain compare is enough.
  assign date_wrap = (date_bcd >= dim_cur);
  assign date_inc  = date_wrap ? DATE_FIRST : bcd_inc(date_bcd);

  always_comb begin
    op = OP_IDLE;
    if (day_carry)     op = OP_AUTO;
    else if (inc_mon)  op = OP_SET_MON;
    else if (inc_date) op = OP_SET_DATE;
  end

  always_comb begin
    mon_d        = mon_bcd;
    date_d       = date_bcd;
    year_carry_d = 1'b0;
    case (op)
      OP_AUTO: begin
        date_d = date_inc;
        if (date_wrap) begin
          mon_d        = mon_inc;
          year_carry_d = mon_wrap;
        end
      end
      OP_SET_MON: begin
        mon_d  = mon_inc;
        date_d = (date_bcd > dim_nxt) ? dim_nxt : date_bcd;
      end
      OP_SET_DATE: begin
        date_d = date_inc;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mon_bcd    <= INIT_MON;
      date_bcd   <= INIT_DATE;
      year_carry <= 1'b0;
    end else begin
      mon_bcd    <= mon_d;
      date_bcd   <= date_d;
      year_carry <= year_carry_d;
    end
  end

endmodule

// File: tb/tb_mon_date_counter.sv
module tb_mon_date_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       day_carry = 1'b0;
  logic       inc_mon   = 1'b0;
  logic       inc_date  = 1'b0;
  logic       leap_year = 1'b0;
  logic [7:0] mon_bcd;
  logic [7:0] date_bcd;
  logic       year_carry;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference calendar state in plain integers.
  int   mm;
  int   md;
  logic myc;

  mon_date_counter dut (
    .clk        (clk),
    .rst        (rst),
    .day_carry  (day_carry),
    .inc_mon    (inc_mon),
    .inc_date   (inc_date),
    .leap_year  (leap_year),
    .mon_bcd    (mon_bcd),
    .date_bcd   (date_bcd),
    .year_carry (year_carry)
  );

  always #5 clk = ~clk;

  function automatic int days_in(input int m, input logic leap);
    int d;
    if (m == 2)                                    d = leap ? 29 : 28;
    else if (m == 4 || m == 6 || m == 9 || m == 11) d = 30;
    else                                           d = 31;
    return d;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) + (v % 10));
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  always @(posedge clk or posedge rst) begin
    int m, d, dim;
    logic y;
    if (rst) begin
      mm  <= 1;
      md  <= 1;
      myc <= 1'b0;
    end else begin
      m   = mm;
      d   = md;
      y   = 1'b0;
      dim = days_in(m, leap_year);
      if (day_carry) begin
        if (d >= dim) begin
          d = 1;
          if (m == 12) begin m = 1; y = 1'b1; end
          else m = m + 1;
        end else d = d + 1;
      end else if (inc_mon) begin
        m = (m % 12) + 1;
        if (d > days_in(m, leap_year)) d = days_in(m, leap_year);
      end else if (inc_date) begin
        d = (d >= dim) ? 1 : d + 1;
      end
      mm  <= m;
      md  <= d;
      myc <= y;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model plus a range/BCD sanity check.
  always @(negedge clk) begin
    logic ok;
    int   mv, dv;
    chk("model_mon",  mon_bcd,  to_bcd(mm));
    chk("model_date", date_bcd, to_bcd(md));
    chk("model_yc",   {7'd0, year_carry}, {7'd0, myc});
    mv = from_bcd(mon_bcd);
    dv = from_bcd(date_bcd);
    ok = (mon_bcd[3:0] <= 4'd9) && (mon_bcd[7:4] <= 4'd9) &&
         (date_bcd[3:0] <= 4'd9) && (date_bcd[7:4] <= 4'd9) &&
         (mv >= 1) && (mv <= 12) && (dv >= 1) && (dv <= 31);
    chk("range", {7'd0, ok}, 8'd1);
  end

  task automatic pulse(input logic dc, input logic im, input logic id);
    @(negedge clk);
    day_carry = dc;
    inc_mon   = im;
    inc_date  = id;
    @(negedge clk);
    day_carry = 1'b0;
    inc_mon   = 1'b0;
    inc_date  = 1'b0;
  endtask

  // Steer to a given date using only set pulses, tracking progress via the model.
  task automatic goto_md(input int m, input int d);
    for (int i = 0; i < 12 && mm != m; i++) pulse(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 31 && md != d; i++) pulse(1'b0, 1'b0, 1'b1);
    if (mm != m || md != d) begin
      n_cmp++;
      n_bad++;
      $display("FAIL goto: reached %0d/%0d wanted %0d/%0d", mm, md, m, d);
    end
  endtask

  task automatic expect_md(input string name, input logic [7:0] m, input logic [7:0] d,
                           input logic yc);
    chk({name, "_mon"},  mon_bcd,  m);
    chk({name, "_date"}, date_bcd, d);
    chk({name, "_yc"},   {7'd0, year_carry}, {7'd0, yc});
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expect_md("reset", 8'h01, 8'h01, 1'b0);

    leap_year = 1'b0;
    goto_md(2, 28);
    pulse(1'b1, 1'b0, 1'b0);
    expect_md("feb28_noleap", 8'h03, 8'h01, 1'b0);

    leap_year = 1'b1;
    goto_md(2, 28);
    pulse(1'b1, 1'b0, 1'b0);
    expect_md("feb28_leap", 8'h02, 8'h29, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    expect_md("feb29_leap", 8'h03, 8'h01, 1'b0);
    leap_year = 1'b0;

    goto_md(12, 31);
    pulse(1'b1, 1'b0, 1'b0);
    expect_md("year_roll", 8'h01, 8'h01, 1'b1);
    @(negedge clk);
    expect_md("year_roll_after", 8'h01, 8'h01, 1'b0);

    goto_md(1, 31);
    pulse(1'b0, 1'b1, 1'b0);
    expect_md("clamp_feb", 8'h02, 8'h28, 1'b0);
    for (int i = 0; i < 10; i++) pulse(1'b0, 1'b1, 1'b0);
    expect_md("set_dec", 8'h12, 8'h28, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    expect_md("set_wrap_jan", 8'h01, 8'h28, 1'b0);

    goto_md(4, 30);
    pulse(1'b0, 1'b0, 1'b1);
    expect_md("date_wrap_apr", 8'h04, 8'h01, 1'b0);

    goto_md(3, 31);
    pulse(1'b1, 1'b1, 1'b0);
    expect_md("prio_dc_mon", 8'h04, 8'h01, 1'b0);

    goto_md(5, 10);
    pulse(1'b0, 1'b1, 1'b1);
    expect_md("prio_mon_date", 8'h06, 8'h10, 1'b0);

    // Stale 29 Feb after leap_year drops.
    leap_year = 1'b1;
    goto_md(2, 29);
    leap_year = 1'b0;
    pulse(1'b0, 1'b0, 1'b1);
    expect_md("stale29_setdate", 8'h02, 8'h01, 1'b0);
    leap_year = 1'b1;
    goto_md(2, 29);
    leap_year = 1'b0;
    pulse(1'b1, 1'b0, 1'b0);
    expect_md("stale29_auto", 8'h03, 8'h01, 1'b0);

    // Asynchronous reset between clock edges.
    goto_md(7, 15);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 expect_md("async_reset", 8'h01, 8'h01, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      day_carry = ($urandom_range(3) == 0);
      inc_mon   = ($urandom_range(15) == 0);
      inc_date  = ($urandom_range(7) == 0);
      if ($urandom_range(199) == 0) leap_year = ~leap_year;
    end
    @(negedge clk);
    day_carry = 1'b0;
    inc_mon   = 1'b0;
    inc_date  = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule
